// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: routes the ioctl ROM download to the Tutankham boards and holds PCB reset until both images verify
module rom_load_sequencer #(
  parameter logic [24:0] CPU_SIZE = 25'h0F000,
  parameter logic [24:0] SND_SIZE = 25'h02000,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [24:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        wr_cpu,
  output logic        wr_snd,
  output logic        pcb_hold,
  output logic        load_done,
  output logic        size_err
);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, RUN} state_t;
  state_t state, state_nxt;
  logic dl_q, rng_err, rise, fall, is_cpu, is_snd, ld_wr, acc_cpu, acc_snd, chk_img, img_ok;
  logic [7:0] idx_q;
  logic [24:0] cnt;
  logic [1:0] valid, valid_nxt;
  logic [RW-1:0] rel_cnt;
  always_comb begin
    rise = ioctl_download && !dl_q;
    fall = !ioctl_download && dl_q;
    is_cpu = idx_q == 8'd0;
    is_snd = idx_q == 8'd1;
    ld_wr = state == LOAD && ioctl_wr && (is_cpu || is_snd);
    acc_cpu = ld_wr && is_cpu && ioctl_addr < CPU_SIZE;
    acc_snd = ld_wr && is_snd && ioctl_addr < SND_SIZE;
    chk_img = state == CHECK && (is_cpu || is_snd);
    img_ok = cnt == (is_cpu ? CPU_SIZE : SND_SIZE) && !rng_err;
    valid_nxt = valid | {chk_img && img_ok && is_snd, chk_img && img_ok && is_cpu};
  end
  always_comb begin
    state_nxt = rise ? LOAD :
                (state == LOAD && fall) ? CHECK :
                (state == CHECK) ? (&valid_nxt ? RELEASE : IDLE) :
                (state == RELEASE && rel_cnt == RW'(RELEASE_CYCLES - 1)) ? RUN : state;
    pcb_hold = state != RUN;
    load_done = state == RUN;
  end
  always_ff @(posedge clk_49m or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_49m or negedge reset)
    if (!reset) begin
      dl_q <= 1'b0;
      idx_q <= '0;
      cnt <= '0;
      rng_err <= 1'b0;
      valid <= '0;
      size_err <= 1'b0;
      rel_cnt <= '0;
      wr_cpu <= 1'b0;
      wr_snd <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      dl_q <= ioctl_download;
      wr_cpu <= acc_cpu;
      wr_snd <= acc_snd;
      if (acc_cpu || acc_snd) begin
        rom_addr <= ioctl_addr;
        rom_data <= ioctl_data;
      end
      rel_cnt <= state == RELEASE ? rel_cnt + 1'b1 : '0;
      if (rise) begin
        idx_q <= ioctl_index;
        cnt <= '0;
        rng_err <= 1'b0;
        valid <= valid & ~{ioctl_index == 8'd1, ioctl_index == 8'd0};
      end else begin
        valid <= valid_nxt;
        if (ld_wr) begin
          cnt <= &cnt ? cnt : cnt + 25'd1;
          rng_err <= rng_err || !(acc_cpu || acc_snd);
        end
        if (chk_img) size_err <= !img_ok;
      end
    end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed self-checking bench for rom_load_sequencer
module tb_rom_load_sequencer;
  logic clk_49m = 1'b0;
  logic reset, ioctl_download, ioctl_wr;
  logic [7:0] ioctl_index, ioctl_data, rom_data;
  logic [24:0] ioctl_addr, rom_addr;
  logic wr_cpu, wr_snd, pcb_hold, load_done, size_err;
  int n_cmp = 0, n_fail = 0;
  int n_cpu = 0, n_snd = 0, bad_strobe = 0;
  int s_cpu, s_snd;
  logic [24:0] last_addr;
  logic last_wr;
  typedef struct {
    logic dl, wr;
    logic [7:0] idx;
    logic [24:0] addr;
    logic [7:0] data;
    logic e_cpu, e_snd, e_hold, e_done, e_serr;
    logic [24:0] e_addr;
    logic [7:0] e_data;
  } vec_t;
  vec_t tbl [11];
  rom_load_sequencer dut (
    .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .rom_addr(rom_addr),
    .rom_data(rom_data), .wr_cpu(wr_cpu), .wr_snd(wr_snd), .pcb_hold(pcb_hold),
    .load_done(load_done), .size_err(size_err)
  );
  always #5 clk_49m = ~clk_49m;
  always @(posedge clk_49m) begin
    last_addr <= ioctl_addr;
    last_wr <= ioctl_wr;
  end
  always @(negedge clk_49m) begin
    if (wr_cpu) n_cpu++;
    if (wr_snd) n_snd++;
    if ((wr_cpu || wr_snd) && (rom_addr !== last_addr || last_wr !== 1'b1 || (wr_cpu && wr_snd))) bad_strobe++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run_session(input logic [7:0] idx, input int n, input logic fall_wr, input logic [24:0] oob_addr, input logic oob);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    ioctl_wr = 1'b0;
    @(negedge clk_49m);
    chk("start_hold", 32'(pcb_hold), 32'd1);
    chk("start_done", 32'(load_done), 32'd0);
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = 8'(i) ^ 8'h5A;
      if (fall_wr && i == n - 1) ioctl_download = 1'b0;
      @(negedge clk_49m);
    end
    if (oob) begin
      ioctl_wr = 1'b1;
      ioctl_addr = oob_addr;
      ioctl_data = oob_addr[7:0] ^ 8'h5A;
      @(negedge clk_49m);
    end
    ioctl_wr = 1'b0;
    if (!fall_wr) begin
      ioctl_download = 1'b0;
      @(negedge clk_49m);
    end
  endtask
  task automatic wait_release(input string nm, input logic rel);
    repeat (16) @(negedge clk_49m);
    chk({nm, "_hold17"}, 32'(pcb_hold), 32'd1);
    chk({nm, "_done17"}, 32'(load_done), 32'd0);
    @(negedge clk_49m);
    chk({nm, "_hold18"}, 32'(pcb_hold), 32'(!rel));
    chk({nm, "_done18"}, 32'(load_done), 32'(rel));
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'd0, 25'h00005, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00000, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'd1, 25'h00006, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00000, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 25'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00000, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 8'd0, 25'h00000, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00000, 8'h5A};
    tbl[4]  = '{1'b1, 1'b0, 8'd0, 25'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00000, 8'h5A};
    tbl[5]  = '{1'b1, 1'b1, 8'd0, 25'h0EFFF, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h0EFFF, 8'hA5};
    tbl[6]  = '{1'b1, 1'b1, 8'd0, 25'h0F000, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h0EFFF, 8'hA5};
    tbl[7]  = '{1'b1, 1'b1, 8'd0, 25'h00010, 8'h4A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00010, 8'h4A};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, 25'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 25'h00010, 8'h4A};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, 25'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 25'h00010, 8'h4A};
    tbl[10] = '{1'b0, 1'b1, 8'd0, 25'h00003, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 25'h00010, 8'h4A};
    reset = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_data = '0;
    repeat (3) @(negedge clk_49m);
    chk("rst_hold", 32'(pcb_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_wr", 32'({wr_cpu, wr_snd}), 32'd0);
    chk("rst_serr", 32'(size_err), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_data", 32'(rom_data), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ioctl_download = tbl[i].dl;
      ioctl_wr = tbl[i].wr;
      ioctl_index = tbl[i].idx;
      ioctl_addr = tbl[i].addr;
      ioctl_data = tbl[i].data;
      @(negedge clk_49m);
      chk($sformatf("v%0d_cpu", i), 32'(wr_cpu), 32'(tbl[i].e_cpu));
      chk($sformatf("v%0d_snd", i), 32'(wr_snd), 32'(tbl[i].e_snd));
      chk($sformatf("v%0d_hold", i), 32'(pcb_hold), 32'(tbl[i].e_hold));
      chk($sformatf("v%0d_done", i), 32'(load_done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d_serr", i), 32'(size_err), 32'(tbl[i].e_serr));
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_data", i), 32'(rom_data), 32'(tbl[i].e_data));
    end
    ioctl_wr = 1'b0;
    @(negedge clk_49m);
    s_cpu = n_cpu;
    run_session(8'd0, 'hF000, 1'b0, 25'h0, 1'b0);
    wait_release("cpu", 1'b0);
    chk("cpu_pulses", 32'(n_cpu - s_cpu), 32'hF000);
    chk("cpu_serr", 32'(size_err), 32'd0);
    chk("cpu_last_addr", 32'(rom_addr), 32'h0EFFF);
    s_snd = n_snd;
    run_session(8'd1, 'h1FFF, 1'b0, 25'h0, 1'b0);
    wait_release("short", 1'b0);
    chk("short_pulses", 32'(n_snd - s_snd), 32'h1FFF);
    chk("short_serr", 32'(size_err), 32'd1);
    s_snd = n_snd;
    run_session(8'd1, 'h2000, 1'b1, 25'h0, 1'b0);
    chk("fall_wr_snd", 32'(wr_snd), 32'd1);
    chk("fall_addr", 32'(rom_addr), 32'h01FFF);
    chk("fall_data", 32'(rom_data), 32'hA5);
    wait_release("full", 1'b1);
    chk("full_pulses", 32'(n_snd - s_snd), 32'h2000);
    chk("full_serr", 32'(size_err), 32'd0);
    s_cpu = n_cpu;
    s_snd = n_snd;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h00100;
    ioctl_index = 8'd0;
    repeat (4) @(negedge clk_49m);
    ioctl_wr = 1'b0;
    @(negedge clk_49m);
    chk("nosess_pulses", 32'((n_cpu - s_cpu) + (n_snd - s_snd)), 32'd0);
    chk("nosess_done", 32'(load_done), 32'd1);
    chk("nosess_hold", 32'(pcb_hold), 32'd0);
    chk("nosess_addr", 32'(rom_addr), 32'h01FFF);
    run_session(8'd2, 16, 1'b0, 25'h0, 1'b0);
    wait_release("keymap", 1'b1);
    chk("keymap_pulses", 32'((n_cpu - s_cpu) + (n_snd - s_snd)), 32'd0);
    chk("keymap_serr", 32'(size_err), 32'd0);
    s_snd = n_snd;
    run_session(8'd1, 'h1FFF, 1'b0, 25'h02000, 1'b1);
    wait_release("range", 1'b0);
    chk("range_pulses", 32'(n_snd - s_snd), 32'h1FFF);
    chk("range_serr", 32'(size_err), 32'd1);
    chk("range_addr", 32'(rom_addr), 32'h01FFE);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    @(negedge clk_49m);
    for (int i = 0; i < 5; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = 8'(i) ^ 8'h5A;
      @(negedge clk_49m);
    end
    chk("prerst_wr_cpu", 32'(wr_cpu), 32'd1);
    #2;
    reset = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("midrst_wr_cpu", 32'(wr_cpu), 32'd0);
    chk("midrst_hold", 32'(pcb_hold), 32'd1);
    chk("midrst_done", 32'(load_done), 32'd0);
    chk("midrst_serr", 32'(size_err), 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_data", 32'(rom_data), 32'd0);
    s_cpu = n_cpu;
    repeat (3) @(negedge clk_49m);
    reset = 1'b1;
    repeat (4) @(negedge clk_49m);
    ioctl_wr = 1'b0;
    @(negedge clk_49m);
    chk("postrst_pulses", 32'(n_cpu - s_cpu), 32'd0);
    chk("postrst_hold", 32'(pcb_hold), 32'd1);
    chk("strobe_addr_latency", 32'(bad_strobe), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences the MiSTer ROM download into the Tutankham main CPU board and sound board. It registers the ioctl stream and routes each byte to a per-board write strobe by index. It verifies the byte count of each image and holds both PCBs in reset until every image has loaded. It sits between the HPS ioctl interface and the `Tutankham` top level, replacing the ad-hoc index filtering there.

## Interface
- `CPU_SIZE`, 25'h0F000, exact byte count of the index-0 image (6 program ROMs + 9 bank ROMs, 4 KB each)
- `SND_SIZE`, 25'h02000, exact byte count of the index-1 image (sound ROM)
- `RELEASE_CYCLES`, 16, clk_49m cycles `pcb_hold` stays high after both images are valid

- `clk_49m` in 1: 49.152 MHz system clock
- `reset` in 1: asynchronous, active-low reset
- `ioctl_download` in 1: HPS download session active
- `ioctl_index` in 8: image index, stable for the whole session
- `ioctl_addr` in 25: byte address
- `ioctl_data` in 8: byte data
- `ioctl_wr` in 1: one-cycle write strobe
- `rom_addr` out 25: registered copy of `ioctl_addr` for the accepted write
- `rom_data` out 8: registered copy of `ioctl_data`
- `wr_cpu` out 1: one-cycle write strobe to the main CPU board
- `wr_snd` out 1: one-cycle write strobe to the sound board
- `pcb_hold` out 1: active-high reset request to both PCBs
- `load_done` out 1: both images loaded with correct size
- `size_err` out 1: sticky; the last finished session had a count mismatch or an out-of-range write

## Operation
- States: IDLE, LOAD, CHECK, RELEASE, RUN.
- IDLE: `pcb_hold`=1. Waits for the rising edge of `ioctl_download`.
- Session start (download rising edge, from any state):
  - Go to LOAD and force `pcb_hold`=1.
  - Clear the 25-bit write counter and the range-error bit.
  - Clear `valid[ioctl_index]`. Indices other than 0 and 1 clear nothing.
- LOAD, on `ioctl_wr`:
  - Index 0: if `ioctl_addr` < `CPU_SIZE`, pulse `wr_cpu`; otherwise set range-error.
  - Index 1: if `ioctl_addr` < `SND_SIZE`, pulse `wr_snd`; otherwise set range-error.
  - Any other index: no strobe, no counting. Keymaps and other indices pass through harmlessly.
  - The counter increments on every index-0/1 write, in or out of range, and saturates at all-ones.
- Download falling edge: go to CHECK.
- CHECK, one cycle, index 0/1 sessions only:
  - Set `valid[idx]` if count == size and there was no range-error.
  - Otherwise set `size_err`.
  - `size_err` clears on the next successful CHECK.
  - Next state: RELEASE if `valid[0]&valid[1]`, else IDLE.
- RELEASE: counts `RELEASE_CYCLES`, then goes to RUN and drops `pcb_hold`.
- RUN: `pcb_hold`=0, `load_done`=1. A new session re-enters LOAD, which re-asserts hold.
- `ioctl_wr` outside a session is ignored entirely: no strobe, no count.

## Timing
- Reset values: state IDLE, `pcb_hold`=1, `wr_cpu`=`wr_snd`=0, `load_done`=0, `size_err`=0, `rom_addr`=0, `rom_data`=0, `valid`=2'b00.
- Write latency: `ioctl_wr` at cycle N gives `wr_*`, `rom_addr` and `rom_data` at N+1, all valid in the same cycle.
- `rom_addr` and `rom_data` update only on accepted writes and hold otherwise.
- Download edges are detected from a registered copy of `ioctl_download`, so a state change occurs 1 cycle after the edge.
- A write coincident with the falling edge is still accepted and counted. CHECK evaluates one cycle later and includes it.
- A new rising edge while in RELEASE aborts the release; hold stays asserted.
- Hold release timing: `pcb_hold` falls exactly `RELEASE_CYCLES`+2 cycles after the download falling edge that completes the second image.
- `load_done` rises in the same cycle that `pcb_hold` falls. It drops 1 cycle after any session-start edge.
- `reset` asserted mid-load returns to IDLE immediately, clears `valid`, and truncates any strobe in progress.

## Test plan
- **Both images, correct size:** index 0 with 0xF000 sequential writes, then index 1 with 0x2000 writes. Expect 0xF000 `wr_cpu` pulses and 0x2000 `wr_snd` pulses. `pcb_hold` falls 18 cycles after the second download falls; then `load_done`=1 and `size_err`=0.
- **Short image:** index 1 with 0x1FFF writes. Expect `size_err`=1 and `pcb_hold` still 1. A reload of index 1 with 0x2000 writes (after index 0 is valid) clears `size_err` and releases hold.
- **Out-of-range write:** index 0, 0xF000 writes plus one write at addr 0xF000. Expect no strobe for that byte, `size_err`=1, and no release.
- **Write with no session:** `ioctl_wr`=1 with `ioctl_download`=0. Expect no strobes and unchanged state. A write on the falling-edge cycle (addr 0x1FFF, data 0xA5) gives `wr_snd` with `rom_data`=0xA5 and completes a valid image.
- **Reload during RUN:** start an index-0 session. Expect `pcb_hold`=1 and `load_done`=0 one cycle after the rising edge. After a correct image, hold releases again.
- **Reset mid-load:** drop `reset` during index-0 writes. Expect immediate IDLE, `pcb_hold`=1, `valid` cleared, and no further strobes.
